instruction_fetch_unit: RTL and testbench

Instruction fetch (IF) stage of the RV32IM pipeline, sitting directly upstream of the decode stage that hosts the control unit. It owns the program counter and issues read requests to instruction memory under a busy-wait handshake. It absorbs stalls through a one-entry holding buffer and handles taken branch/jump redirects. It drives the IF/ID pipeline register whose instruction opcode, funct3 and funct7 bits feed the control unit.

---
 rtl/instruction_fetch_unit_if.sv | 9 +
 rtl/instruction_fetch_unit.sv | 89 ++++++++
 tb/tb_instruction_fetch_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction memory busy-wait read bus between the fetch unit and memory.
interface instruction_fetch_unit_if;
    logic        read;
    logic [31:0] address;
    logic [31:0] readdata;
    logic        busywait;
    modport master (output read, address, input readdata, busywait);
    modport slave (input read, address, output readdata, busywait);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: RV32 IF stage with one-entry hold buffer and redirect handling.
// Optional perf counters (perf_fetched, perf_bubbles) when IF_PERF_COUNTERS_EN is defined.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pc_src_en,
    input  logic [31:0]               pc_target,
    input  logic                      stall,
    input  logic                      flush,
    instruction_fetch_unit_if.master  imem,
    output logic [31:0]               if_id_pc,
    output logic [31:0]               if_id_pc_4,
    output logic [31:0]               if_id_instruction,
    output logic                      if_id_valid,
    output logic                      fetch_busy
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_bubbles
`endif
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT, REQ, HOLD, DISCARD} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, hold_data, target;
    logic got, advance, load_valid, load_bubble;

    always_comb begin
        target = pc_target & ~32'h3;
        got = state == REQ && !imem.busywait;
        advance = !stall && (got || state == HOLD);
        load_valid = !flush && advance;
        load_bubble = flush || (!stall && ((state == REQ && imem.busywait) || state == DISCARD));
        pc_n = pc_src_en ? target : advance ? pc + 32'd4 : pc;
        // a redirect during an in-flight busy read must let that read finish at its old address
        state_n = pc_src_en ? (((state == REQ || state == DISCARD) && imem.busywait) ? DISCARD : REQ) :
                  state == BOOT ? REQ :
                  state == REQ ? ((got && stall) ? HOLD : REQ) :
                  state == HOLD ? (stall ? HOLD : REQ) :
                  (imem.busywait ? DISCARD : REQ);
    end

    assign fetch_busy = (state == REQ && imem.busywait) || state == DISCARD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc <= RESET_PC;
            imem.address <= RESET_PC;
            imem.read <= 1'b0;
            hold_data <= '0;
            if_id_pc <= '0;
            if_id_pc_4 <= '0;
            if_id_instruction <= NOP;
            if_id_valid <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            imem.address <= state_n == DISCARD ? imem.address : pc_n;
            imem.read <= state_n == REQ || state_n == DISCARD;
            hold_data <= pc_src_en ? '0 : (got && stall) ? imem.readdata : hold_data;
            if (load_bubble) begin
                if_id_pc <= '0;
                if_id_pc_4 <= '0;
                if_id_instruction <= NOP;
                if_id_valid <= 1'b0;
            end else if (load_valid) begin
                if_id_pc <= pc;
                if_id_pc_4 <= pc + 32'd4;
                if_id_instruction <= state == HOLD ? hold_data : imem.readdata;
                if_id_valid <= 1'b1;
            end
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (load_valid && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
            if (load_bubble && perf_bubbles != '1) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized bench for instruction_fetch_unit against a behavioural fetch model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 0, rst_n = 0, pc_src_en = 0, stall = 0, flush = 0, bw = 0;
    logic [31:0] pc_target = 0;
    logic [31:0] if_id_pc, if_id_pc_4, if_id_instruction;
    logic if_id_valid, fetch_busy;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif
    int n_checks = 0, n_fail = 0;

    // model: booting, requesting at m_addr, holding a fetched word, or discarding a stale read
    bit m_boot, m_read, m_hold, m_disc, e_valid;
    logic [31:0] m_pc, m_addr, m_word, e_pc, e_pc4, e_ins, m_fetched, m_bubbles;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h0 ? 32'h0000_0537 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    instruction_fetch_unit_if ifc();
    assign ifc.busywait = bw;
    assign ifc.readdata = bw ? 32'hDEAD_BEEF : mem(ifc.address);

    instruction_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .pc_src_en(pc_src_en), .pc_target(pc_target),
        .stall(stall), .flush(flush), .imem(ifc),
        .if_id_pc(if_id_pc), .if_id_pc_4(if_id_pc_4), .if_id_instruction(if_id_instruction),
        .if_id_valid(if_id_valid), .fetch_busy(fetch_busy)
`ifdef IF_PERF_COUNTERS_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset;
        m_boot = 1; m_read = 0; m_hold = 0; m_disc = 0;
        m_pc = 0; m_addr = 0; m_word = 0;
        e_valid = 0; e_pc = 0; e_pc4 = 0; e_ins = NOP;
        m_fetched = 0; m_bubbles = 0;
    endtask

    task automatic bubble;
        e_valid = 0; e_pc = 0; e_pc4 = 0; e_ins = NOP;
        m_bubbles++;
    endtask

    task automatic step;
        bit ok;
        ok = m_read && !m_disc && !bw;
        if (flush) bubble();
        else if (!stall && (m_hold || ok)) begin
            e_valid = 1; e_pc = m_pc; e_pc4 = m_pc + 4;
            e_ins = m_hold ? m_word : mem(m_pc);
            m_fetched++;
        end else if (!stall && m_read) bubble();
        if (pc_src_en) begin
            m_disc = m_read && bw;
            m_pc = pc_target & ~32'h3;
            m_hold = 0; m_boot = 0; m_read = 1;
            if (!m_disc) m_addr = m_pc;
        end else if (m_boot) begin
            m_boot = 0; m_read = 1;
        end else if (m_disc) begin
            if (!bw) begin m_disc = 0; m_addr = m_pc; end
        end else if (m_hold) begin
            if (!stall) begin m_hold = 0; m_read = 1; m_pc += 4; m_addr = m_pc; end
        end else if (ok) begin
            if (stall) begin m_hold = 1; m_word = mem(m_pc); m_read = 0; end
            else begin m_pc += 4; m_addr = m_pc; end
        end
    endtask

    task automatic check_all;
        chk("imem_read", ifc.read, m_read);
        chk("imem_address", ifc.address, m_addr);
        chk("if_id_pc", if_id_pc, e_pc);
        chk("if_id_pc_4", if_id_pc_4, e_pc4);
        chk("if_id_instruction", if_id_instruction, e_ins);
        chk("if_id_valid", if_id_valid, e_valid);
`ifdef IF_PERF_COUNTERS_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
    endtask

    task automatic cyc(input logic b, input logic s, input logic r, input logic f, input logic [31:0] t);
        bw = b; stall = s; pc_src_en = r; flush = f; pc_target = t;
        #1;
        chk("fetch_busy", fetch_busy, (m_read && !m_disc && bw) || m_disc);
        @(posedge clk);
        step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic b, s, r, f;
        logic [31:0] t;
        model_reset();
        #12;
        chk("rst_read", ifc.read, 0);
        chk("rst_addr", ifc.address, 0);
        chk("rst_ins", if_id_instruction, NOP);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_busy", fetch_busy, 0);
        chk("rst_pc", if_id_pc, 0);
        @(negedge clk);
        rst_n = 1;
        cyc(0, 0, 0, 0, 0);
        chk("boot_valid", if_id_valid, 0);
        cyc(0, 0, 0, 0, 0);
        chk("first_valid", if_id_valid, 1);
        chk("first_pc", if_id_pc, 0);
        chk("first_pc4", if_id_pc_4, 4);
        chk("first_ins", if_id_instruction, 32'h0000_0537);
        chk("first_next_addr", ifc.address, 4);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk("wait_busy", fetch_busy, 1);
            chk("wait_valid", if_id_valid, 0);
            chk("wait_ins", if_id_instruction, NOP);
        end
        cyc(0, 0, 0, 0, 0);
        chk("after_wait_pc", if_id_pc, 8);
`ifdef IF_PERF_COUNTERS_EN
        chk("wait_bubbles", perf_bubbles, 3);
`endif
        cyc(0, 1, 0, 0, 0);
        chk("stall_pc", if_id_pc, 8);
        chk("stall_read", ifc.read, 0);
        cyc(0, 1, 0, 0, 0);
        chk("stall2_pc", if_id_pc, 8);
        cyc(0, 0, 0, 0, 0);
        chk("unstall_pc", if_id_pc, 12);
        chk("unstall_addr", ifc.address, 16);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 32'h0000_0103);
        chk("redir_valid", if_id_valid, 0);
        chk("redir_addr_held", ifc.address, 20);
        chk("redir_busy", fetch_busy, 1);
        cyc(0, 0, 0, 0, 0);
        chk("redir_new_addr", ifc.address, 32'h100);
        chk("redir_dropped", if_id_valid, 0);
        cyc(0, 0, 0, 0, 0);
        chk("redir_pc", if_id_pc, 32'h100);
        chk("redir_load_valid", if_id_valid, 1);
        cyc(0, 0, 1, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);
        chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_id_pc_4, 0);
        chk("wrap_addr", ifc.address, 0);
        for (int i = 0; i < 3000; i++) begin
            b = $urandom_range(99) < 30;
            s = $urandom_range(99) < 25;
            r = !m_disc && ($urandom_range(99) < 8);
            f = r || ($urandom_range(19) == 0);
            t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            cyc(b, s, r, f, t);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_read", ifc.read, 0);
        chk("async_rst_ins", if_id_instruction, NOP);
        chk("async_rst_valid", if_id_valid, 0);
        chk("async_rst_busy", fetch_busy, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        bw = 0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rerun_valid", if_id_valid, 1);
        chk("rerun_ins", if_id_instruction, 32'h0000_0537);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
